// File: rtl/toy_sch_cpu.sv
// 8-bit accumulator micro-sequencer: fetch/decode/operand/execute/out/halt over a
// shared byte-wide memory bus, with the sequencer state exported one-hot.
module toy_sch_cpu (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] D_IN,
  output logic [7:0] ADDR,
  output logic [7:0] D_OUT,
  output logic       MEM_EN,
  output logic       RORW,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5
);
  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_OPERAND = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_OUT     = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h08;
  localparam logic [7:0] OP_XOR  = 8'h10;
  localparam logic [7:0] OP_HALT = 8'h80;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opr_q, opr_d;
  logic [7:0] acc_q, acc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = D_IN;
        pc_d    = pc_q + 8'd1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Unrecognised opcodes fall through as 2-cycle NOPs.
        case (ir_q)
          OP_LDI, OP_ADD, OP_AND, OP_XOR: state_d = ST_OPERAND;
          OP_OUT:                         state_d = ST_OUT;
          OP_HALT:                        state_d = ST_HALT;
          default:                        state_d = ST_FETCH;
        endcase
      end
      ST_OPERAND: begin
        opr_d   = D_IN;
        pc_d    = pc_q + 8'd1;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (ir_q)
          OP_LDI:  acc_d = opr_q;
          OP_ADD:  acc_d = acc_q + opr_q;
          OP_AND:  acc_d = acc_q & opr_q;
          OP_XOR:  acc_d = acc_q ^ opr_q;
          default: acc_d = acc_q;
        endcase
        state_d = ST_FETCH;
      end
      ST_OUT:  state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
      acc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
    end
  end

  // Moore outputs: pure decodes of registered state, so no D_IN feedthrough.
  assign ADDR   = (state_q == ST_OUT) ? 8'hFF : pc_q;
  assign D_OUT  = acc_q;
  assign MEM_EN = (state_q == ST_FETCH) || (state_q == ST_OPERAND) || (state_q == ST_OUT);
  assign RORW   = (state_q != ST_OUT);
  assign S0     = (state_q == ST_FETCH);
  assign S1     = (state_q == ST_DECODE);
  assign S2     = (state_q == ST_OPERAND);
  assign S3     = (state_q == ST_EXECUTE);
  assign S4     = (state_q == ST_OUT);
  assign S5     = (state_q == ST_HALT);
endmodule

// File: tb/tb_toy_sch_cpu.sv
// Bench for toy_sch_cpu: instruction-level reference model expands each opcode
// into its expected per-cycle bus/state trace and compares every cycle.
module tb_toy_sch_cpu;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] D_IN, ADDR, D_OUT;
  logic       MEM_EN, RORW, S0, S1, S2, S3, S4, S5;

  logic [7:0] mem [256];
  assign D_IN = mem[ADDR];

  toy_sch_cpu dut (
    .CLK(CLK), .RESET(RESET), .D_IN(D_IN), .ADDR(ADDR), .D_OUT(D_OUT),
    .MEM_EN(MEM_EN), .RORW(RORW),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, act, exp);
    end
  endtask

  // {S5..S0, ADDR, MEM_EN, RORW, D_OUT}; RORW is don't-care while MEM_EN=0.
  function automatic logic [23:0] vec(input int st, input logic [7:0] a,
                                      input logic men, input logic rw, input logic [7:0] d);
    logic [5:0] oh;
    oh = 6'b1 << st;
    return {oh, a, men, men ? rw : 1'b1, d};
  endfunction

  function automatic logic [23:0] act();
    return {S5, S4, S3, S2, S1, S0, ADDR, MEM_EN, MEM_EN ? RORW : 1'b1, D_OUT};
  endfunction

  // Reference model: architectural state plus a queue of expected cycles.
  logic [7:0]  mpc, macc;
  logic        halted;
  logic [23:0] expq [$];

  task automatic model_reset();
    expq.delete();
    mpc = 8'h00; macc = 8'h00; halted = 1'b0;
  endtask

  task automatic refill();
    logic [7:0] op, opr;
    if (halted) begin
      expq.push_back(vec(5, mpc, 1'b0, 1'b1, macc));
      return;
    end
    op = mem[mpc];
    expq.push_back(vec(0, mpc, 1'b1, 1'b1, macc));
    mpc = mpc + 8'd1;
    expq.push_back(vec(1, mpc, 1'b0, 1'b1, macc));
    if (op == 8'h01 || op == 8'h02 || op == 8'h08 || op == 8'h10) begin
      opr = mem[mpc];
      expq.push_back(vec(2, mpc, 1'b1, 1'b1, macc));
      mpc = mpc + 8'd1;
      expq.push_back(vec(3, mpc, 1'b0, 1'b1, macc));
      case (op)
        8'h01:   macc = opr;
        8'h02:   macc = 8'((int'(macc) + int'(opr)) % 256);
        8'h08:   macc = macc & opr;
        default: macc = macc ^ opr;
      endcase
    end else if (op == 8'h04) begin
      expq.push_back(vec(4, 8'hFF, 1'b1, 1'b0, macc));
    end else if (op == 8'h80) begin
      halted = 1'b1;
      expq.push_back(vec(5, mpc, 1'b0, 1'b1, macc));
    end
  endtask

  task automatic run(input string tag, input int n);
    logic [23:0] e;
    for (int i = 0; i < n; i++) begin
      if (expq.size() == 0) refill();
      e = expq.pop_front();
      chk(tag, act(), e);
      @(negedge CLK);
    end
  endtask

  localparam logic [23:0] RST_VEC = {6'b000001, 8'h00, 1'b1, 1'b1, 8'h00};

  // Asynchronous reset pulse starting mid-cycle; released on a falling edge.
  task automatic rst_pulse(input string tag);
    #1 RESET = 1'b0;
    #1 chk(tag, act(), RST_VEC);
    @(negedge CLK);
    chk(tag, act(), RST_VEC);
    RESET = 1'b1;
    model_reset();
  endtask

  task automatic load(input logic [7:0] p [$]);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < p.size(); i++) mem[i] = p[i];
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) return 8'h00;
    if (r < 35) return 8'h01;
    if (r < 50) return 8'h02;
    if (r < 60) return 8'h08;
    if (r < 70) return 8'h10;
    if (r < 82) return 8'h04;
    if (r < 84) return 8'h80;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    RESET = 1'b0;
    model_reset();
    #135;
    chk("reset_hold", act(), RST_VEC);
    @(negedge CLK);
    RESET = 1'b1;

    // Load + output, with a reset abort while in EXECUTE.
    load('{8'h01, 8'hAA, 8'h04});
    rst_pulse("reset_pre");
    run("ldi_s0s2", 3);
    chk("in_s3", act(), vec(3, 8'h02, 1'b0, 1'b1, 8'h00));
    rst_pulse("reset_mid_s3");
    run("ldi_out", 12);

    load('{8'h01, 8'hFE, 8'h02, 8'h01, 8'h02, 8'h01, 8'h04});
    rst_pulse("reset_arith");
    run("arith", 24);

    load('{8'h01, 8'hFF, 8'h10, 8'hFF, 8'h04, 8'h01, 8'h0F, 8'h08, 8'hCC, 8'h04});
    rst_pulse("reset_logic");
    run("logic", 30);

    load('{8'h01, 8'h5C, 8'h00, 8'h23, 8'h04});
    rst_pulse("reset_nop");
    run("nop_illegal", 16);

    load('{8'h01, 8'h33, 8'h80, 8'h04});
    rst_pulse("reset_halt");
    run("halt", 24);
    rst_pulse("reset_from_halt");
    run("after_halt", 6);

    // Operand at 0xFF, then the PC wraps to fetch 0x00.
    load('{8'h00});
    mem[8'hFE] = 8'h01;
    mem[8'hFF] = 8'h5A;
    mem[8'h00] = 8'h04;
    rst_pulse("reset_wrap");
    run("wrap", 530);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_op();
      rst_pulse("reset_rand");
      run("rand", 300);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/toy_sch_cpu.md
# toy_sch_cpu

8-bit accumulator micro-sequencer with a shared, byte-wide memory bus. It fetches one-byte opcodes and optional one-byte immediates from external memory, updates an accumulator, and writes the accumulator to an output location. It sits between a synchronous-read memory/IO model and the board-level state indicators. The current sequencer state is exported as six one-hot lines.

## Interface
- Parameters: none.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- D_IN  in  8  read data from memory; sampled on the rising edge ending a read state.
- ADDR  out  8  memory address.
- D_OUT  out  8  write data; always equals ACC.
- MEM_EN  out  1  memory access enable.
- RORW  out  1  1 = read, 0 = write; meaningful only while MEM_EN=1.
- S0..S5  out  1 each  one-hot state indicators.

## Operation
- Internal registers: PC[7:0], IR[7:0], OPR[7:0], ACC[7:0], 3-bit state.
- States and outputs (Moore, decoded from the state register):
  - S0 FETCH: MEM_EN=1, RORW=1, ADDR=PC. Edge: IR<=D_IN, PC<=PC+1, go to S1.
  - S1 DECODE: MEM_EN=0, RORW=1, ADDR=PC.
    - 0x01/0x02/0x08/0x10 go to S2.
    - 0x04 goes to S4.
    - 0x80 goes to S5.
    - Any other value (incl. 0x00) is a NOP and goes to S0.
  - S2 OPERAND: MEM_EN=1, RORW=1, ADDR=PC. Edge: OPR<=D_IN, PC<=PC+1, go to S3.
  - S3 EXECUTE: MEM_EN=0, ADDR=PC. Edge: ACC update by IR, then go to S0.
    - 0x01 LDI: ACC<=OPR.
    - 0x02 ADD: ACC<=ACC+OPR, mod 256, carry discarded.
    - 0x08 AND: ACC<=ACC&OPR.
    - 0x10 XOR: ACC<=ACC^OPR.
  - S4 OUT: MEM_EN=1, RORW=0, ADDR=0xFF, D_OUT=ACC. Edge: go to S0. No register changes.
  - S5 HALT: MEM_EN=0, RORW=1, ADDR=PC. Remains in S5 until reset.
- Exactly one of S0..S5 is high at all times.
- PC wraps 0xFF -> 0x00 with no flag.
- An OUT write to 0xFF may alias program memory at 0xFF; the memory model owns that decode.

## Timing
- Reset (RESET=0, asynchronous): state=S0, PC=0, IR=0, OPR=0, ACC=0.
- Outputs during reset: S0=1, S1..S5=0, ADDR=0x00, MEM_EN=1, RORW=1, D_OUT=0x00.
- Reset deassertion is synchronized: the first fetch edge is the first rising CLK edge after RESET returns high.
- Reset asserted in any state, including mid-instruction or HALT, aborts immediately to the reset values.
- Memory is synchronous-read: D_IN must be valid at the rising edge that ends S0 or S2.
- Instruction latency, start of S0 to the next S0:
  - NOP / illegal: 2 cycles.
  - OUT: 3 cycles.
  - LDI / ADD / AND / XOR: 4 cycles.
- ACC changes on the edge leaving S3; D_OUT follows in the same cycle.
- Outputs are glitch-free registered-state decodes. D_IN is never used combinationally.

## Test plan
- Reset: hold RESET=0 for 135 ns → S0=1, ADDR=0, MEM_EN=1, RORW=1, D_OUT=0. Assert reset mid-S3 → immediate return to these values.
- Load and output: memory 0x01,0xAA,0x04 → states S0,S1,S2,S3,S0,S1,S4. D_OUT=0xAA after S3. In S4, ADDR=0xFF, RORW=0, MEM_EN=1.
- Arithmetic: 0x01,0xFE,0x02,0x01 → ACC=0xFF. Then 0x02,0x01 → ACC=0x00 (wrap, carry dropped).
- Logic: with ACC=0xFF, 0x10,0xFF → 0x00. Then 0x01,0x0F, 0x08,0xCC → 0x0C.
- NOP and illegal: opcodes 0x00 and 0x23 → 2-cycle S0→S1→S0, ACC unchanged, PC+1 each.
- Halt and wrap: 0x80 → S5 held for 10+ cycles with MEM_EN=0. Separately, executing through PC=0xFF → next fetch at ADDR=0x00.
